reg_bus_initiator: RTL

REG_BUS_INITIATOR -- requirements
Module: reg_bus_initiator

---
 rtl/reg_bus_pkg.sv | 18 +
 rtl/reg_bus_initiator.sv | 133 +++++++++++++
 2 files changed

// File: rtl/reg_bus_pkg.sv
// Shared types for the register-bus initiator.
// Holds the FSM state encoding and the latched transfer direction.
package reg_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        CAPTURE,
        RESP
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

endpackage

// File: rtl/reg_bus_initiator.sv
// Register-bus initiator: turns a valid/ready request into one-cycle bus strobes and a held response.
// Define REG_BUS_WRITE_READBACK_EN to read back every write and flag a mismatch on rsp_err.
module reg_bus_initiator
    import reg_bus_pkg::*;
#(
    parameter int width        = 8,
    parameter int addressWidth = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [addressWidth-1:0] req_addr,
    input  logic [width-1:0]        req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [width-1:0]        rsp_rdata,
    output logic                    rsp_err,
    output logic [addressWidth-1:0] address,
    output logic                    writeEnable,
    output logic [width-1:0]        writeData,
    output logic                    readEnable,
    input  logic [width-1:0]        readData
);

    // state   | meaning
    // IDLE    | waiting for a request (req_ready high)
    // WRITE   | writeEnable strobe, one cycle
    // READ    | readEnable strobe, one cycle
    // CAPTURE | responder presents readData; latch it
    // RESP    | rsp_valid held until rsp_ready

    state_t                  r_state;
    state_t                  w_next;
    op_t                     r_op;
    logic [addressWidth-1:0] r_addr;
    logic [width-1:0]        r_wdata;
    logic [width-1:0]        r_rdata;
    logic                    w_accept;

    assign w_accept = req_valid && (r_state == IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next = req_write ? WRITE : READ;
                end
            end
            WRITE: begin
`ifdef REG_BUS_WRITE_READBACK_EN
                w_next = READ;
`else
                w_next = RESP;
`endif
            end
            READ:    w_next = CAPTURE;
            CAPTURE: w_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        writeEnable = 1'b0;
        readEnable  = 1'b0;
        case (r_state)
            IDLE:    req_ready   = 1'b1;
            WRITE:   writeEnable = (r_op == OP_WRITE);
            READ:    readEnable  = 1'b1;
            RESP:    rsp_valid   = 1'b1;
            default: ;
        endcase
    end

    // Write data is only replaced by writes so the bus keeps its last written value across reads.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_op    <= OP_READ;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else if (w_accept) begin
            r_op   <= req_write ? OP_WRITE : OP_READ;
            r_addr <= req_addr;
            if (req_write) begin
                r_wdata <= req_wdata;
            end
            r_rdata <= '0;
        end else if (r_state == CAPTURE) begin
            r_rdata <= readData;
        end
    end

`ifdef REG_BUS_WRITE_READBACK_EN
    logic r_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (r_state == CAPTURE) begin
            r_err <= (r_op == OP_WRITE) && (readData != r_wdata);
        end
    end

    assign rsp_err = r_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign address   = r_addr;
    assign writeData = r_wdata;
    assign rsp_rdata = r_rdata;

endmodule
